// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch/decode sequencer
//
// Purpose: basic-computer timing states, the register-I/O opcode, and default
// address/data widths shared by fetch_unit and fetch_unit_pc_counter.
// Ports: none (package).
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    // Opcode 7 is register/IO reference: IR[15] is not an indirect bit there.
    localparam logic [2:0] OPC_REGIO = 3'b111;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T0       = 3'd1,
        T1       = 3'd2,
        T2       = 3'd3,
        T3       = 3'd4,
        DISPATCH = 3'd5
    } state_t;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// rtl/fetch_unit_pc_counter.sv - program counter register with increment and load
//
// Purpose: ADDR_W-bit program counter, synchronous active-high reset to RESET_PC.
//   Load has priority over increment; increment wraps at 2**ADDR_W.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   inc      in   increment by one this cycle
//   load     in   load load_val this cycle (wins over inc)
//   load_val in   ADDR_W value to load
//   pc       out  ADDR_W current count
module fetch_unit_pc_counter
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch/decode sequencer for the basic computer
//
// Purpose: walks T0..T3 against a combinational-read main memory, holds PC/AR/IR,
//   and offers the decoded instruction to execute through instr_valid/instr_ack.
//   Build option FETCH_INDIRECT_EN: when defined, memory-reference indirect
//   instructions take an extra T3 cycle (AR<-M[AR]); when undefined, T2 always
//   dispatches and execute resolves indirection from ind.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   run           in   keep fetching while high; low parks in IDLE after dispatch
//   mem_adress    out  memory address (always AR)
//   mem_read      out  memory read strobe (T1, T3)
//   mem_write     out  memory write strobe (always 0)
//   mem_outdata   in   combinational memory read data
//   instr_valid   out  decoded instruction presented (DISPATCH)
//   instr_ack     in   execute accepts the instruction
//   ir, opcode, ind, ar, pc   out  decoded instruction state
//   pc_load, pc_in            in   branch target loaded on accepted dispatch
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_adress,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_outdata,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic              ind,
    output logic [ADDR_W-1:0] ar,
    output logic [ADDR_W-1:0] pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in
);

    state_t state_q, state_d;
    logic   pc_inc;
    logic   pc_ld;

    fetch_unit_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (pc_inc),
        .load     (pc_ld),
        .load_val (pc_in),
        .pc       (pc)
    );

    assign opcode     = ir[14:12];
    assign ind        = ir[15];
    assign mem_adress = ar;
    assign mem_write  = 1'b0;

`ifdef FETCH_INDIRECT_EN
    // Register-I/O instructions reuse bit 15 for other purposes, so only
    // memory-reference opcodes take the indirect cycle.
    logic ind_mem_ref;
    assign ind_mem_ref = ir[15] && (ir[14:12] != OPC_REGIO);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar <= '0;
            ir <= '0;
        end else begin
            case (state_q)
                T0: ar <= pc;
                T1: ir <= mem_outdata;
                T2: ar <= ir[ADDR_W-1:0];
`ifdef FETCH_INDIRECT_EN
                T3: ar <= mem_outdata[ADDR_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        instr_valid = 1'b0;
        pc_inc      = 1'b0;
        pc_ld       = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = T0;
            end
            T0: begin
                state_d = T1;
            end
            T1: begin
                mem_read = 1'b1;
                pc_inc   = 1'b1;
                state_d  = T2;
            end
            T2: begin
`ifdef FETCH_INDIRECT_EN
                state_d = ind_mem_ref ? T3 : DISPATCH;
`else
                state_d = DISPATCH;
`endif
            end
            T3: begin
`ifdef FETCH_INDIRECT_EN
                mem_read = 1'b1;
                state_d  = DISPATCH;
`else
                state_d  = IDLE;
`endif
            end
            DISPATCH: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    pc_ld   = pc_load;
                    state_d = run ? T0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
